mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Single-port memory controller that shares one byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Serialises 8/16/32-bit loads and stores into byte cycles, little-endian.
- Arbitrates IF against MEM, with MEM given priority.
- Raises a stall request so the pipeline control holds upstream stages while a MEM access is outstanding.

Parameters:
- ADDR_W, 32, byte-address width of requests and of the RAM port.
- DATA_W, 32, request data width; fixed at 32 for a 4-byte maximum.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  instruction fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  abort the in-flight or pending fetch (branch redirect).
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  out  32  fetched word, little-endian assembled.
- mem_req  in  1  MEM-stage access request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_addr  in  ADDR_W  access byte address.
- mem_wdata  in  32  store data; low bytes are used.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  32  load data, zero-extended; sign extension is done by the MEM stage.
- stall_req  out  1  equals mem_req AND NOT mem_done (combinational).
- ram_addr  out  ADDR_W  RAM byte address (registered).
- ram_we  out  1  RAM write strobe (registered).
- ram_dout  out  8  RAM write byte (registered).
- ram_din  in  8  RAM read byte; valid one cycle after ram_addr is presented.

Behaviour:
- Reset (asynchronous): state IDLE, counter 0.
  - Outputs reset to 0: ram_addr, ram_we, ram_dout, if_done, mem_done, if_data, mem_rdata.
  - Reset mid-transaction aborts it. A partially written word is left partially written.
- States: IDLE, RD, WR, DONE.
- Accepting a request (only from IDLE):
  - If mem_req=1, the MEM request wins; otherwise if_req=1 with if_flush=0 is accepted.
  - Request fields are latched at acceptance (cycle T).
  - N = bytes: 1, 2 or 4; IF is always 4.
- Read (RD):
  - ram_addr = addr+k during cycle T+1+k, for k = 0..N-1, with ram_we=0.
  - Byte k is sampled from ram_din at the end of cycle T+2+k into lane k.
  - The done pulse and data are presented in cycle T+N+2 (DONE state).
- Write (WR):
  - During cycle T+1+k: ram_we=1, ram_addr=addr+k, ram_dout=wdata[8k+7:8k].
  - mem_done is asserted in cycle T+N+1 (DONE state), with ram_we=0.
- DONE: lasts one cycle, then the controller goes to IDLE. No acceptance in DONE, so a requester must drop or change req the cycle after done.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W; there is no alignment check.
- Unread lanes of mem_rdata are 0. mem_rdata and if_data hold their value until the next completion of the same requester.
- if_flush:
  - In IDLE, it blocks IF acceptance that cycle.
  - During an IF read, the controller returns to IDLE next cycle with no if_done; ram_we stays 0.
  - It has no effect on MEM transactions.
- A mem_req arriving while IF is in flight waits for the IF to finish (no preemption). stall_req is asserted meanwhile.
- Only one of if_done / mem_done is ever high in a cycle.

Decomposition:
- Shared package (defs): MEM_LEN_BYTE/HALF/WORD codes, state encodings, RAM read latency (1) and the byte-count decode.
- One natural sub-module, mem_ctrl_lane: a byte-lane slicer/assembler (write byte select by k, read byte insert by k with lane clear at start).
- FSM, arbitration and counter stay in mem_ctrl.

Test Plan:
1. Store word at 0x100, wdata 0x11223344, accepted at T: ram_we=1 with bytes 44,33,22,11 at 0x100..0x103 in T+1..T+4; mem_done at T+5; stall_req low from T+5.
2. RAM 0x100..0x103 = 44,33,22,11; load word at T: mem_rdata=0x11223344 with mem_done at T+6; load byte at 0x102 gives 0x00000022 at T+3.
3. if_req(0x200) and mem_req (load half 0x100) both high at T: MEM serviced first, mem_rdata=0x00003344 at T+4; IF accepted at T+5, if_done at T+11.
4. IF read of 0x300 accepted at T, if_flush at T+2: no if_done; IDLE at T+3; a new if_req(0x400) gives if_done with the correct word 6 cycles after acceptance.
5. Load half at 0xFFFFFFFF: ram_addr shows 0xFFFFFFFF, then 0x00000000; lanes assemble in that order.
6. rst asserted asynchronously mid-store at T+2: all outputs 0 immediately; bytes 0-1 written, bytes 2-3 untouched; a fresh request after release completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: access-size codes,
// FSM states, RAM read latency and the access-size to byte-count decode.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd2;

  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Code 3 is not a legal size and is treated as a word access.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      MEM_LEN_BYTE: return 3'd1;
      MEM_LEN_HALF: return 3'd2;
      MEM_LEN_WORD: return 3'd4;
      default:      return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the fetch port, MEM-stage port and byte-wide RAM port.
// The slave modport is the controller's view; master is the pipeline/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [DATA_W-1:0] if_data;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, stall_req, ram_addr, ram_we, ram_dout
  );

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, stall_req, ram_addr, ram_we, ram_dout
  );
endinterface

// File: rtl/mem_ctrl_lane.sv
// Byte-lane slicer/assembler: picks store byte i_wsel out of i_wdata and inserts
// the RAM byte into lane i_rsel of the accumulator (zeroed on the first byte).
module mem_ctrl_lane #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_wsel,
  output logic [7:0]        o_wbyte,
  input  logic [DATA_W-1:0] i_acc,
  input  logic              i_clr,
  input  logic [7:0]        i_din,
  input  logic [1:0]        i_rsel,
  output logic [DATA_W-1:0] o_acc
);

  always_comb begin
    o_wbyte = i_wdata[{i_wsel, 3'b000} +: 8];
    o_acc   = i_clr ? '0 : i_acc;
    o_acc[{i_rsel, 3'b000} +: 8] = i_din;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising 1/2/4-byte little-endian accesses; MEM wins arbitration in IDLE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  localparam logic [2:0] RD_LAT = 3'(RAM_RD_LAT);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic              r_is_if;
  logic [2:0]        r_nbytes;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_acc;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic              r_ram_we, w_ram_we_nxt;
  logic [7:0]        r_ram_dout, w_ram_dout_nxt;
  logic              r_if_done, w_if_done_nxt;
  logic              r_mem_done, w_mem_done_nxt;
  logic [DATA_W-1:0] r_if_data, r_mem_rdata;

  logic              w_accept_mem, w_accept_if, w_flush, w_sample;
  logic              w_rd_last, w_wr_last, w_lane_clr;
  logic [2:0]        w_nbytes;
  logic [DATA_W-1:0] w_lane_wdata, w_acc_nxt;
  logic [1:0]        w_wsel, w_rsel;
  logic [7:0]        w_wbyte;

  assign w_accept_mem = (r_state == S_IDLE) && bus.mem_req;
  assign w_accept_if  = (r_state == S_IDLE) && !bus.mem_req && bus.if_req && !bus.if_flush;
  assign w_nbytes     = w_accept_mem ? len_to_bytes(bus.mem_len) : 3'd4;
  assign w_flush      = (r_state == S_RD) && r_is_if && bus.if_flush;
  // Reads run RD_LAT cycles longer than writes because ram_din lags ram_addr.
  assign w_rd_last    = (r_cnt == r_nbytes + RD_LAT - 3'd1);
  assign w_wr_last    = (r_cnt == r_nbytes - 3'd1);
  assign w_sample     = (r_state == S_RD) && (r_cnt >= RD_LAT) && !w_flush;
  assign w_lane_clr   = (r_cnt == RD_LAT);
  assign w_lane_wdata = w_accept_mem ? bus.mem_wdata : r_wdata;
  assign w_wsel       = w_accept_mem ? 2'd0 : 2'(r_cnt + 3'd1);
  assign w_rsel       = 2'(r_cnt - RD_LAT);

  mem_ctrl_lane #(.DATA_W(DATA_W)) u_lane (
    .i_wdata (w_lane_wdata),
    .i_wsel  (w_wsel),
    .o_wbyte (w_wbyte),
    .i_acc   (r_acc),
    .i_clr   (w_lane_clr),
    .i_din   (bus.ram_din),
    .i_rsel  (w_rsel),
    .o_acc   (w_acc_nxt)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_we_nxt   = 1'b0;
    w_ram_dout_nxt = r_ram_dout;
    w_if_done_nxt  = 1'b0;
    w_mem_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept_mem) begin
          w_state_nxt    = bus.mem_we ? S_WR : S_RD;
          w_cnt_nxt      = '0;
          w_ram_addr_nxt = bus.mem_addr;
          w_ram_we_nxt   = bus.mem_we;
          w_ram_dout_nxt = w_wbyte;
        end else if (w_accept_if) begin
          w_state_nxt    = S_RD;
          w_cnt_nxt      = '0;
          w_ram_addr_nxt = bus.if_addr;
        end
      end
      S_RD: begin
        if (w_flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_rd_last) begin
          w_state_nxt    = S_DONE;
          w_if_done_nxt  = r_is_if;
          w_mem_done_nxt = !r_is_if;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt + 3'd1 < r_nbytes)
            w_ram_addr_nxt = r_addr + ADDR_W'(r_cnt + 3'd1);
        end
      end
      S_WR: begin
        if (w_wr_last) begin
          w_state_nxt    = S_DONE;
          w_mem_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt      = r_cnt + 3'd1;
          w_ram_addr_nxt = r_addr + ADDR_W'(r_cnt + 3'd1);
          w_ram_we_nxt   = 1'b1;
          w_ram_dout_nxt = w_wbyte;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_dout  <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_dout <= w_ram_dout_nxt;
      r_if_done  <= w_if_done_nxt;
      r_mem_done <= w_mem_done_nxt;
      if (w_sample && w_rd_last) begin
        if (r_is_if) r_if_data   <= w_acc_nxt;
        else         r_mem_rdata <= w_acc_nxt;
      end
    end
  end

  // Request fields and the assembly accumulator are only read inside a transaction.
  always_ff @(posedge clk) begin
    if (w_accept_mem || w_accept_if) begin
      r_is_if  <= w_accept_if;
      r_nbytes <= w_nbytes;
      r_addr   <= w_accept_mem ? bus.mem_addr : bus.if_addr;
      r_wdata  <= bus.mem_wdata;
    end
    if (w_sample) r_acc <= w_acc_nxt;
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_dout  = r_ram_dout;
  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.stall_req = bus.mem_req && !r_mem_done;

endmodule
